// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default queue entry for a 32-bit PC; the top re-declares it for other XLEN.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: small synchronous FIFO of {pc, instr} entries.
// Flush has priority over push; pop on an empty queue is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fq_entry_t,
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem_q  [DEPTH];
  entry_t        mem_d  [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Next-state: flush rewinds both pointers, else independent push/pop.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(do_pop);
    end
  end

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

  // The credit rule upstream must keep the queue from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-based IMEM issue,
// response capture into the fetch queue, valid/ready hand-off to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fu_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   count;
  logic [CW:0]     inflight;
  logic            push, pop;
  fu_entry_t       push_data, head;

  // Issue decision: credit covers queued + in-flight; a redirect always issues.
  always_comb begin
    inflight   = {1'b0, count} + {{CW{1'b0}}, pending_q};
    imem_addr  = redirect_valid ? (redirect_pc & ~XLEN'(3)) : fetch_pc_q;
    imem_req   = ~RST & ((inflight < (CW+1)'(FQ_DEPTH)) | redirect_valid);
    fetch_pc_d = imem_req ? imem_addr + XLEN'(PC_STEP) : fetch_pc_q;
    addr_d     = imem_req ? imem_addr : addr_q;
    pending_d  = imem_req;
  end

  // PC, address of the outstanding request and the pending flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
    end
  end

  // Response capture and decode hand-off; a redirect kills both this cycle.
  always_comb begin
    push            = pending_q & ~redirect_valid;
    push_data.pc    = addr_q;
    push_data.instr = imem_rdata;
    out_valid       = (count != '0) & ~redirect_valid;
    pop             = out_valid & out_ready;
    out_pc          = head.pc;
    out_instr       = head.instr;
  end

  fetch_fifo #(
    .entry_t (fu_entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end replacing the bare free-running PC register. Generates PCs, issues requests to the synchronous IMEM, and buffers returned instructions with their PCs in a fetch queue. Hands instructions to the CPU decode stage over a valid/ready handshake. Supports redirects (branch/jump) that flush wrong-path state.

Parameters:
XLEN, 32, PC and address width in bits (instruction width fixed at 32)
RESET_PC, 32'h0000_0000, first fetch address after reset
FQ_DEPTH, 4, fetch-queue entries (power of two, >= 2)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
imem_req  output  1  IMEM read request this cycle
imem_addr  output  XLEN  IMEM byte address, bits [1:0] always 0
imem_rdata  input  32  IMEM read data, valid the cycle after imem_req
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  restart address, bits [1:0] ignored (treated as 0)
out_valid  output  1  out_pc/out_instr hold a valid instruction
out_ready  input  1  decode accepts this cycle
out_pc  output  XLEN  PC of presented instruction
out_instr  output  32  presented instruction

Behaviour:
- Reset (RST=1, asynchronous): fetch_pc=RESET_PC, queue empty, pending=0; imem_req=0, out_valid=0, out_pc=0, out_instr=0. Outputs stay at these values for as long as RST is held.
- IMEM contract: fixed 1-cycle read latency, never stalls; at most one request outstanding (pending flag).
- Issue rule: imem_req=1 when (count + pending) < FQ_DEPTH or redirect_valid=1. imem_addr = redirect_valid ? {redirect_pc[XLEN-1:2],2'b00} : fetch_pc.
- On an issue, fetch_pc <= imem_addr + 4 (modulo 2^XLEN; 0xFFFF_FFFC wraps to 0), pending <= 1. Otherwise pending <= 0.
- Response: in the cycle after an issue, {addr, imem_rdata} is pushed at the edge. The push is suppressed if redirect_valid=1 in that cycle (wrong-path response).
- Latency: request in cycle t, push at end of t+1, out_valid=1 in cycle t+2.
- Throughput: 1 instr/cycle sustained while out_ready=1.
- Output: out_valid = (count != 0) & ~redirect_valid. Head entry drives out_pc/out_instr, which are held stable while out_valid & ~out_ready. Pop on out_valid & out_ready.
- Redirect: queue count <= 0 and any response arriving that cycle is dropped. The new request to redirect_pc is issued in the same cycle, so the first redirected instruction is presented 2 cycles later.
- Simultaneous push and pop: count unchanged.
- Full queue: no issue (credit rule), so overflow is impossible. An assertion flags any push while count==FQ_DEPTH.
- Empty queue with out_ready=1: no pop, no underflow.
- Reset mid-operation: pending response discarded, queue cleared, restart at RESET_PC one cycle after RST falls.

Decomposition:
- Package fetch_pkg: INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0013, fq_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO of fq_entry_t, parameter FQ_DEPTH, with push, pop, flush, count. Flush has priority over push.
- fetch_unit holds the PC/credit/pending logic and instantiates fetch_fifo.

Test Plan:
- Reset release with RESET_PC=0 and out_ready=1, IMEM returning word index -> imem_addr 0,4,8,12 on consecutive cycles; first out_valid 2 cycles after the first request; out_pc 0,4,8 back-to-back.
- out_ready=0 for 10 cycles (FQ_DEPTH=4) -> exactly 4 requests issued, count=4, imem_req=0 afterwards; out_pc stays 0; releasing out_ready drains 0,4,8,12 in order.
- redirect_valid with redirect_pc=0x103 while queue holds 3 entries and a request is pending -> imem_addr=0x100 that cycle; wrong-path response dropped; next out_pc=0x100 two cycles later, then 0x104.
- Redirect in the same cycle as out_valid & out_ready -> out_valid forced 0, no pop counted, queue empty the next cycle.
- fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0000_0000.
- RST asserted asynchronously mid-stream (between edges) -> out_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC with no stale instruction delivered.
